// File: rtl/mem_ram_hs_if.sv
// Request/response channel between a load/store master and the mem_ram_hs data RAM.
interface mem_ram_hs_if #(
  parameter int DATA_W = 32
);
  localparam int BYTES = DATA_W / 8;

  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [BYTES-1:0]  req_wmask;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_addr, req_wdata, req_wmask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wmask,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/mem_ram_hs.sv
// Single-port data RAM with valid/ready requests, byte write mask, READ_LAT-deep
// response pipeline (1 or 2) and an optional post-reset zeroing sequence.
module mem_ram_hs #(
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 1024,
  parameter int READ_LAT   = 1,
  parameter int CLEAR_INIT = 1
) (
  input  logic        clk,
  input  logic        reset,
  mem_ram_hs_if.slave bus
);
  localparam int          BYTES    = DATA_W / 8;
  localparam int          IDX_W    = $clog2(DEPTH);
  localparam int          LSB_W    = $clog2(BYTES);
  localparam logic [31:0] LOW_MASK = 32'(BYTES - 1);

  typedef enum logic {
    S_CLEAR,
    S_READY
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  clr_idx;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              addr_err;
  logic              is_write;
  logic [IDX_W-1:0]  idx;

  logic [READ_LAT-1:0] pipe_valid;
  logic [READ_LAT-1:0] pipe_err;
  logic [DATA_W-1:0]   pipe_data [READ_LAT];

  assign accept   = bus.req_valid && bus.req_ready;
  assign idx      = bus.req_addr[LSB_W +: IDX_W];
  assign is_write = (bus.req_wmask != '0);
  // Any set bit above the word index means the address lies beyond the array.
  assign addr_err = ((bus.req_addr & LOW_MASK) != '0) ||
                    ((bus.req_addr >> (LSB_W + IDX_W)) != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= (CLEAR_INIT != 0) ? S_CLEAR : S_READY;
      clr_idx       <= '0;
      bus.req_ready <= 1'b0;
      bus.busy      <= (CLEAR_INIT != 0);
    end else begin
      case (state)
        S_CLEAR: begin
          bus.req_ready <= 1'b0;
          bus.busy      <= 1'b1;
          if (clr_idx == IDX_W'(DEPTH - 1)) begin
            state         <= S_READY;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        S_READY: begin
          bus.req_ready <= 1'b1;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

  // Storage has no reset; only the clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_idx] <= '0;
    end else if (accept && is_write && !addr_err) begin
      for (int b = 0; b < BYTES; b++) begin
        if (bus.req_wmask[b]) begin
          mem[idx][8*b +: 8] <= bus.req_wdata[8*b +: 8];
        end
      end
    end
  end

  // Data/err stages only load behind a valid so the outputs hold between responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int s = 0; s < READ_LAT; s++) begin
        pipe_data[s] <= '0;
      end
    end else begin
      pipe_valid[0] <= accept;
      if (accept) begin
        pipe_err[0]  <= addr_err;
        pipe_data[0] <= (addr_err || is_write) ? '0 : mem[idx];
      end
      for (int s = 1; s < READ_LAT; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        if (pipe_valid[s-1]) begin
          pipe_err[s]  <= pipe_err[s-1];
          pipe_data[s] <= pipe_data[s-1];
        end
      end
    end
  end

  assign bus.rsp_valid = pipe_valid[READ_LAT-1];
  assign bus.rsp_err   = pipe_err[READ_LAT-1];
  assign bus.rsp_rdata = pipe_data[READ_LAT-1];
endmodule

// File: tb/tb_mem_ram_hs.sv
// Self-checking bench for mem_ram_hs: directed scenarios plus random traffic, all
// responses compared every cycle against a word-array model with a due-time queue.
module tb_mem_ram_hs;
  localparam int DATA_W     = 32;
  localparam int DEPTH      = 16;
  localparam int READ_LAT   = 2;
  localparam int CLEAR_INIT = 1;
  localparam int BYTES      = DATA_W / 8;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int   errors    = 0;
  int   checks    = 0;
  int   cyc       = 0;
  int   rsp_count = 0;

  logic [31:0] model_mem [DEPTH];
  exp_t        exp_q [$];
  logic [31:0] last_exp_data = '0;
  logic        last_exp_err  = 1'b0;
  logic [31:0] last_rsp_data = '0;
  logic        last_rsp_err  = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  mem_ram_hs_if #(.DATA_W(DATA_W)) bus ();

  mem_ram_hs #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .READ_LAT  (READ_LAT),
    .CLEAR_INIT(CLEAR_INIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour of one accepted request, evaluated in acceptance order.
  task automatic modelAccept(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    exp_t e;
    e.due  = cyc + READ_LAT;
    e.data = '0;
    e.err  = 1'b0;
    if ((a % BYTES) != 0 || a >= DEPTH * BYTES) begin
      e.err = 1'b1;
    end else if (m != 4'h0) begin
      for (int b = 0; b < BYTES; b++) begin
        if (m[b]) model_mem[a / BYTES][8*b +: 8] = d[8*b +: 8];
      end
    end else begin
      e.data = model_mem[a / BYTES];
    end
    exp_q.push_back(e);
  endtask

  // Called on a falling edge; the request is seen by the next rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] m);
    bus.req_valid = v;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_wmask = m;
    if (v && bus.req_ready) modelAccept(a, d, m);
    @(negedge clk);
  endtask

  task automatic waitRsp(input int target);
    int n;
    n = 0;
    while (rsp_count < target && n < 20) begin
      applyStimulus(1'b0, '0, '0, '0);
      n++;
    end
    if (rsp_count < target) checkOutput("rsp_wait_timeout", 64'(rsp_count), 64'(target));
  endtask

  task automatic doReset();
    int cnt;
    bus.req_valid = 1'b0;
    bus.req_wmask = '0;
    reset = 1'b1;
    exp_q.delete();
    last_exp_data = '0;
    last_exp_err  = 1'b0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    #1;
    checkOutput("reset_req_ready", 64'(bus.req_ready), 64'd0);
    checkOutput("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    checkOutput("reset_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    checkOutput("reset_rsp_err",   64'(bus.rsp_err),   64'd0);
    checkOutput("reset_busy",      64'(bus.busy),      64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    cnt = 0;
    // Requests presented while clearing must be ignored.
    while (bus.busy && cnt < 100) begin
      cnt++;
      bus.req_valid = 1'b1;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'hFFFF_FFFF;
      bus.req_wmask = 4'hF;
      @(negedge clk);
      #1;
    end
    bus.req_valid = 1'b0;
    bus.req_wmask = '0;
    checkOutput("clear_busy_cycles", 64'(cnt), 64'd16);
    checkOutput("ready_after_clear", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
  endtask

  // Response checker: every cycle, either the oldest due response or idle with held data.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        checkOutput("rsp_valid", 64'(bus.rsp_valid), 64'd1);
        checkOutput("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_q[0].data));
        checkOutput("rsp_err",   64'(bus.rsp_err),   64'(exp_q[0].err));
        last_exp_data = exp_q[0].data;
        last_exp_err  = exp_q[0].err;
        last_rsp_data = bus.rsp_rdata;
        last_rsp_err  = bus.rsp_err;
        rsp_count++;
        void'(exp_q.pop_front());
      end else begin
        checkOutput("rsp_valid_idle", 64'(bus.rsp_valid), 64'd0);
        checkOutput("rsp_rdata_hold", 64'(bus.rsp_rdata), 64'(last_exp_data));
        checkOutput("rsp_err_hold",   64'(bus.rsp_err),   64'(last_exp_err));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          base;
    int          kind;
    logic [31:0] a;
    logic [3:0]  m;
    logic        v;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    @(negedge clk);
    doReset();

    $display("[TB] read after clear");
    base = rsp_count;
    applyStimulus(1'b1, 32'h3C, '0, 4'h0);
    waitRsp(base + 1);
    checkOutput("t1_read_3c", 64'(last_rsp_data), 64'h0);

    $display("[TB] full write and readback");
    base = rsp_count;
    applyStimulus(1'b1, 32'h0, 32'hABCD_EF89, 4'hF);
    applyStimulus(1'b1, 32'h0, '0, 4'h0);
    waitRsp(base + 2);
    checkOutput("t2_readback", 64'(last_rsp_data), 64'hABCD_EF89);

    $display("[TB] byte masked write");
    base = rsp_count;
    applyStimulus(1'b1, 32'h0, 32'h1234_78FF, 4'b0001);
    applyStimulus(1'b1, 32'h0, '0, 4'h0);
    waitRsp(base + 2);
    checkOutput("t3_masked", 64'(last_rsp_data), 64'hABCD_EFFF);

    $display("[TB] misaligned and out of range");
    base = rsp_count;
    applyStimulus(1'b1, 32'h2, '0, 4'h0);
    waitRsp(base + 1);
    checkOutput("t4_misaligned_err",  64'(last_rsp_err),  64'd1);
    checkOutput("t4_misaligned_data", 64'(last_rsp_data), 64'h0);
    base = rsp_count;
    applyStimulus(1'b1, 32'h40, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1'b1, 32'h1, 32'hDEAD_BEEF, 4'hF);
    waitRsp(base + 2);
    checkOutput("t4_range_err", 64'(last_rsp_err), 64'd1);
    base = rsp_count;
    applyStimulus(1'b1, 32'h0, '0, 4'h0);
    waitRsp(base + 1);
    checkOutput("t4_unchanged", 64'(last_rsp_data), 64'hABCD_EFFF);

    $display("[TB] back-to-back writes then reads");
    base = rsp_count;
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'(4 + 4*i), 32'(32'h1111_1111 * (i + 1)), 4'hF);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 32'(4 + 4*i), '0, 4'h0);
    waitRsp(base + 12);
    checkOutput("t5_last_read", 64'(last_rsp_data), 64'h6666_6666);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7)      a = 32'($urandom_range(0, DEPTH - 1) * 4);
      else if (kind < 8) a = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
      else               a = 32'($urandom_range(DEPTH * 4, 32'hFFFF));
      m = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
      v = ($urandom_range(0, 3) != 0);
      applyStimulus(v, a, $urandom, m);
    end
    waitRsp(rsp_count + exp_q.size());

    $display("[TB] reset with reads in flight");
    applyStimulus(1'b1, 32'h3C, 32'h5A5A_5A5A, 4'hF);
    applyStimulus(1'b1, 32'h0, '0, 4'h0);
    applyStimulus(1'b1, 32'h3C, '0, 4'h0);
    bus.req_valid = 1'b0;
    #2;
    doReset();
    base = rsp_count;
    applyStimulus(1'b1, 32'h0, '0, 4'h0);
    applyStimulus(1'b1, 32'h3C, '0, 4'h0);
    waitRsp(base + 2);
    checkOutput("t6_word15_cleared", 64'(last_rsp_data), 64'h0);
    checkOutput("t6_word15_err",     64'(last_rsp_err),  64'd0);

    repeat (4) applyStimulus(1'b0, '0, '0, '0);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
